// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display driver: conversion FSM
// encoding, segment patterns and the double-dabble / leading-zero helpers.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 13;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low patterns ordered {g,f,e,d,c,b,a}, indexed by decimal digit
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // True when digit idx and every more-significant digit are zero (never the units digit)
  function automatic logic leading_zero(input logic [BCD_W-1:0] b, input logic [1:0] idx);
    logic z;
    z = (idx != 2'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && b[4*i +: 4] != 4'd0) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
module bcd_to_7seg
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && nibble <= 4'd9) seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/ssd_display_driver.sv
// Converts a 13-bit binary value to BCD with a serial double-dabble FSM and
// multiplexes the four digits onto an active-low seven-segment display.
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy,
  output logic [BCD_W-1:0]      bcd
);

  localparam int SCAN_W = $clog2(REFRESH_DIV);

  conv_state_t        state, next_state;
  logic [VALUE_W-1:0] shift_reg;
  logic [VALUE_W-1:0] cap_value;
  logic [VALUE_W-1:0] last_value;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   bcd_reg;
  logic [3:0]         cnt;
  logic               first_flag;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic [3:0]         nibble;
  logic               blank_digit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (value != last_value || first_flag) next_state = SHIFT;
      SHIFT:   if (cnt == 4'(VALUE_W - 1)) next_state = LATCH;
      LATCH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Value is only sampled in IDLE, so changes during a conversion wait for the next compare
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      cap_value  <= '0;
      last_value <= '0;
      scratch    <= '0;
      bcd_reg    <= '0;
      cnt        <= '0;
      first_flag <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (next_state == SHIFT) begin
            shift_reg <= value;
            cap_value <= value;
            scratch   <= '0;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          {scratch, shift_reg} <= {bcd_adjust(scratch), shift_reg} << 1;
          cnt                  <= cnt + 4'd1;
        end
        LATCH: begin
          bcd_reg    <= scratch;
          last_value <= cap_value;
          first_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign nibble      = bcd_reg[{digit_idx, 2'b00} +: 4];
  assign blank_digit = blank_lz && leading_zero(bcd_reg, digit_idx);

  bcd_to_7seg u_dec (
    .nibble (nibble),
    .blank  (blank_digit),
    .seg    (seg)
  );

  assign anode = ~(4'b0001 << digit_idx);
  assign dp    = 1'b1;
  assign bcd   = bcd_reg;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Scoreboard bench for ssd_display_driver: conversions are checked by a monitor
// on each busy fall, the scan/segment outputs against hand-computed patterns.
module tb_ssd_display_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic [15:0] bcd;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  int busy_len = 0;
  logic prev_busy = 1'b0;
  logic [15:0] exp_q[$];

  ssd_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .blank_lz (blank_lz),
    .anode    (anode),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy),
    .bcd      (bcd)
  );

  always #5 clk = ~clk;

  // Reference scan position: edges since the scan was last reset
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed conversion must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_len = 0;
      end else if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_conversion", {16'h0, bcd}, 32'hffff_ffff);
        end else begin
          checkOutput("bcd_result", {16'h0, bcd}, {16'h0, exp_q.pop_front()});
          checkOutput("busy_cycles", busy_len, 32'd14);
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic applyStimulus(input logic [12:0] v, input logic [15:0] exp);
    @(posedge clk);
    #1;
    value = v;
    exp_q.push_back(exp);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) checkOutput("conversion_timeout", 32'd0, 32'd1);
  endtask

  task automatic scanCheck(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input int cycles);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int d;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      d = (edges / DIV) % 4;
      exp_an = ~(4'b0001 << d);
      checkOutput({tag, "_anode"}, {28'h0, anode}, {28'h0, exp_an});
      checkOutput({tag, "_seg"}, {25'h0, seg}, {25'h0, exp_seg[d]});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, first displayed cycle, then the power-up conversion of 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_anode", {28'h0, anode}, 32'b1110);
    checkOutput("reset_seg", {25'h0, seg}, 32'b1000000);
    checkOutput("reset_dp", {31'h0, dp}, 32'd1);
    checkOutput("reset_busy", {31'h0, busy}, 32'd0);
    checkOutput("reset_bcd", {16'h0, bcd}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(16'h0000);
    waitDone();
    scanCheck("zero", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4);

    // Maximum value
    applyStimulus(13'd8191, 16'h8191);
    waitDone();

    // Stable value must not retrigger a conversion
    repeat (20) @(negedge clk);
    checkOutput("stable_idle_busy", {31'h0, busy}, 32'd0);

    // Scan sequence over a full rotation
    applyStimulus(13'd1234, 16'h1234);
    waitDone();
    scanCheck("scan1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 16);

    // Leading-zero blanking on and off
    blank_lz = 1'b1;
    applyStimulus(13'd7, 16'h0007);
    waitDone();
    scanCheck("blank7", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111, 16);
    blank_lz = 1'b0;
    scanCheck("noblank7", 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000, 16);

    // Value changed during the 5th SHIFT cycle is converted only afterwards
    applyStimulus(13'd100, 16'h0100);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    value = 13'd200;
    exp_q.push_back(16'h0200);
    waitDone();

    // Embedded zero below a nonzero digit stays visible when blanking
    blank_lz = 1'b1;
    scanCheck("blank200", 7'b1000000, 7'b1000000, 7'b0100100, 7'b1111111, 16);
    blank_lz = 1'b0;

    // Reset on the 7th SHIFT cycle aborts; conversion restarts after release
    applyStimulus(13'd4095, 16'h4095);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", {31'h0, busy}, 32'd0);
    checkOutput("abort_bcd", {16'h0, bcd}, 32'h0);
    checkOutput("abort_anode", {28'h0, anode}, 32'b1110);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitDone();
    checkOutput("final_bcd", {16'h0, bcd}, 32'h4095);
    checkOutput("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
